inst_fetch_unit: RTL

//  Instruction-fetch initiator: owns the PC and drives ce/addr of the combinational

---
 rtl/inst_fetch_unit_if.sv | 31 +++
 rtl/inst_fetch_unit.sv | 90 +++++++++
 2 files changed

// File: rtl/inst_fetch_unit_if.sv
// Fetch-side bus: ROM read port plus the IF/ID valid/ready handshake.
// The fetch unit is the master of both; ROM and decode sit on the slave side.
interface inst_fetch_unit_if;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    modport master (
        output rom_ce,
        output rom_addr,
        input  rom_inst,
        output id_valid,
        output id_pc,
        output id_inst,
        input  id_ready
    );

    modport slave (
        input  rom_ce,
        input  rom_addr,
        output rom_inst,
        input  id_valid,
        input  id_pc,
        input  id_inst,
        output id_ready
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, reads a combinational ROM and buffers {pc, inst}
// pairs in a small FIFO in front of decode; flush/branch redirects empty the FIFO.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               branch_flag,
    input  logic [31:0]        branch_target,
    input  logic               flush,
    input  logic [31:0]        flush_pc,
    inst_fetch_unit_if.master  bus
);
    localparam int unsigned    PtrW    = $clog2(QUEUE_DEPTH);
    localparam int unsigned    CntW    = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(QUEUE_DEPTH);

    logic [31:0]      pc_q, pc_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [31:0]      pc_mem_q   [QUEUE_DEPTH];
    logic [31:0]      inst_mem_q [QUEUE_DEPTH];

    logic        redirect;
    logic        full;
    logic        valid;
    logic        deq;
    logic        fetch;
    logic [31:0] redirect_pc;

    assign redirect    = flush | branch_flag;
    assign redirect_pc = flush ? flush_pc : branch_target;
    assign full        = (count_q == FullCnt);
    assign valid       = ~rst & ~redirect & (count_q != '0);
    assign deq         = valid & bus.id_ready;
    // A full FIFO may still fetch when the head leaves in the same cycle.
    assign fetch       = ~rst & ~redirect & (~full | deq);

    assign bus.rom_ce   = fetch;
    assign bus.rom_addr = fetch ? pc_q : '0;
    assign bus.id_valid = valid;
    assign bus.id_pc    = rst ? '0 : pc_mem_q[rd_ptr_q];
    assign bus.id_inst  = rst ? '0 : inst_mem_q[rd_ptr_q];

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            pc_d     = redirect_pc & 32'hFFFF_FFFC;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (fetch) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(fetch) - CntW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (fetch) begin
            pc_mem_q[wr_ptr_q]   <= pc_q;
            inst_mem_q[wr_ptr_q] <= bus.rom_inst;
        end
    end
endmodule
